// File: rtl/radd_slice_seq.sv
`default_nettype none
// ============================================================================
//  Module   : fulladd / radd_slice_seq
//  Brief    : Multi-cycle wide adder. SLICE bits are added per clock through
//             a chain of fulladd cells. The carry is held in a register
//             between slices. The result is offered on a valid/ready port.
//  Revision : 1.0 - initial release
// ============================================================================

// One-bit full adder cell; kept as its own module so placement names stay
// readable (one instance per slice bit).
module fulladd (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// WIDTH must be a positive multiple of SLICE.
module radd_slice_seq #(
  parameter int WIDTH = 12,
  parameter int SLICE = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] c_LAST_IDX = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  partial_q, partial_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;

  // Slice currently being added, selected by the slice index.
  int                w_base;
  logic [SLICE-1:0]  w_sa;
  logic [SLICE-1:0]  w_sb;
  logic [SLICE-1:0]  w_s;
  logic [SLICE:0]    w_c;

  assign w_base = int'(idx_q) * SLICE;
  assign w_sa   = a_q[w_base +: SLICE];
  assign w_sb   = b_q[w_base +: SLICE];
  assign w_c[0] = carry_q;

  // Ripple chain for one slice: bit i's carry-out feeds bit i+1.
  for (genvar i = 0; i < SLICE; i++) begin : g_fa
    fulladd u_fa (
      .a    (w_sa[i]),
      .b    (w_sb[i]),
      .cin  (w_c[i]),
      .s    (w_s[i]),
      .cout (w_c[i+1])
    );
  end

  // State and datapath registers; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      partial_q <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      carry_q   <= carry_d;
      a_q       <= a_d;
      b_q       <= b_d;
      partial_q <= partial_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
    end
  end

  // Next-state logic: capture in IDLE, one slice per cycle in RUN, and hold
  // the result in DONE until the consumer takes it.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    a_d       = a_q;
    b_d       = b_q;
    partial_d = partial_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_cin;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        partial_d[w_base +: SLICE] = w_s;
        carry_d = w_c[SLICE];
        idx_d   = idx_q + 1'b1;
        if (idx_q == c_LAST_IDX) begin
          // The output word includes the slice written in this same cycle.
          sum_d   = partial_d;
          cout_d  = w_c[SLICE];
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_radd_slice_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_radd_slice_seq
//  Brief    : Self-checking bench for radd_slice_seq. Directed and random adds
//             are compared against a plain-arithmetic reference.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_radd_slice_seq;

  localparam int WIDTH  = 12;
  localparam int SLICE  = 3;
  localparam int NSLICE = WIDTH / SLICE;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc_cyc  = 0;

  radd_slice_seq #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Free-running edge counter used to measure accept spacing.
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: the full-width sum including the carry-out.
  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b,
                                           input logic cin);
    return {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands and wait (bounded) until they are accepted.
  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin);
    int n;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 30) begin
      tick();
      n++;
    end
    chk("accept_wait", in_ready, 1);
    tick();
    acc_cyc = cyc;
  endtask

  // Check latency and result, apply 'hold' cycles of backpressure, then
  // complete the output handshake.
  task automatic finish_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic cin, input int hold, input string tag);
    logic [WIDTH:0] exp;
    int lat;
    exp       = model(a, b, cin);
    out_ready = (hold == 0);
    lat = 0;
    while (!out_valid && lat < 30) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, NSLICE);
    chk({tag, "_sum"}, out_sum, exp[WIDTH-1:0]);
    chk({tag, "_cout"}, out_cout, exp[WIDTH]);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_in_ready_done"}, in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "_hold_valid"}, out_valid, 1);
      chk({tag, "_hold_sum"}, {out_cout, out_sum}, exp);
      chk({tag, "_hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    chk({tag, "_post_valid"}, out_valid, 0);
    chk({tag, "_post_in_ready"}, in_ready, 1);
    chk({tag, "_post_keep"}, {out_cout, out_sum}, exp);
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int a1;
    int seen;
    logic [WIDTH-1:0] ra, rb;
    logic rc;
    int rh;

    // Reset held two cycles with in_valid asserted.
    rst = 1'b1; in_valid = 1'b1; in_a = 12'hABC; in_b = 12'h123; in_cin = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", out_sum, 12'h000);
    chk("rst_cout", out_cout, 0);
    in_valid = 1'b0;
    rst = 1'b0;
    tick();
    chk("rst_no_capture", busy, 0);

    // Basic add.
    start_op(12'h123, 12'h456, 1'b0);
    chk("basic_busy_run", busy, 1);
    finish_op(12'h123, 12'h456, 1'b0, 0, "basic");
    chk("basic_exact", out_sum, 12'h579);

    // Full carry ripple.
    start_op(12'hFFF, 12'h001, 1'b0);
    finish_op(12'hFFF, 12'h001, 1'b0, 0, "ripple1");
    chk("ripple1_exact", {out_cout, out_sum}, 13'h1000);
    start_op(12'hFFF, 12'hFFF, 1'b1);
    finish_op(12'hFFF, 12'hFFF, 1'b1, 0, "ripple2");
    chk("ripple2_exact", {out_cout, out_sum}, 13'h1FFF);

    // Backpressure while new data waits on the input.
    start_op(12'h0A5, 12'h05A, 1'b1);
    in_a = 12'h321; in_b = 12'h123; in_cin = 1'b0;
    finish_op(12'h0A5, 12'h05A, 1'b1, 6, "bp");
    chk("bp_exact", {out_cout, out_sum}, 13'h0100);
    a1 = cyc;
    start_op(12'h321, 12'h123, 1'b0);
    chk("bp_accept_next", acc_cyc - a1, 1);
    finish_op(12'h321, 12'h123, 1'b0, 0, "bp_next");

    // Reset in RUN with idx=2.
    start_op(12'h555, 12'h2AA, 1'b0);
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_sum", out_sum, 12'h000);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid || busy) seen++;
    end
    chk("midrst_no_result", seen, 0);
    start_op(12'h7FF, 12'h001, 1'b0);
    finish_op(12'h7FF, 12'h001, 1'b0, 0, "after_rst");
    chk("after_rst_exact", {out_cout, out_sum}, 13'h0800);

    // Back-to-back operations.
    start_op(12'h111, 12'h222, 1'b0);
    a1 = acc_cyc;
    finish_op(12'h111, 12'h222, 1'b0, 0, "b2b1");
    chk("b2b1_exact", {out_cout, out_sum}, 13'h0333);
    start_op(12'h800, 12'h800, 1'b0);
    chk("b2b_spacing", acc_cyc - a1, NSLICE + 2);
    finish_op(12'h800, 12'h800, 1'b0, 0, "b2b2");
    chk("b2b2_exact", {out_cout, out_sum}, 13'h1000);

    // Randomized operations with random backpressure.
    for (int k = 0; k < 16; k++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom_range(0, 1));
      rh = int'($urandom_range(0, 3));
      start_op(ra, rb, rc);
      finish_op(ra, rb, rc, rh, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
